// File: rtl/vga_frame_pipeline.sv
// vga_frame_pipeline: parametrised VGA timing generator and pixel pipeline.
//
// Generates h/v timing, a linear frame-buffer address and pixel coordinates.
// It selects one of NUM_MODES colour channels using the mode latched at frame
// start, and delays sync/blank so they line up with the channel read latency
// PIPE_LAT.
//
// Optional feature: define VGA_TEST_PATTERN_EN to build an 8-bar colour test
// pattern, selected when the latched mode equals NUM_MODES.
//
// Ports:
//   iVGA_CLK      pixel clock
//   iRST          synchronous active-high reset
//   iMODE         requested screen mode, sampled at (h,v)=(0,0)
//   iRGB          NUM_MODES packed BGR channels, channel k at [24k+23:24k]
//   oADDR         linear pixel address y*H_ACTIVE+x (holds during blanking)
//   oX, oY        pixel coordinates
//   oACTIVE       oX/oY/oADDR refer to a visible pixel
//   oFRAME_START  one-cycle pulse for pixel (0,0)
//   oFRAME_CNT    frame counter, wraps
//   oMODE         mode latched for the current frame
//   oHS, oVS      active-low syncs, aligned with the colour outputs
//   oBLANK_n      high in the visible area, aligned with the colour outputs
//   oB, oG, oR    output colour
module vga_frame_pipeline #(
  parameter int unsigned H_ACTIVE  = 640,
  parameter int unsigned H_FP      = 16,
  parameter int unsigned H_SYNC    = 96,
  parameter int unsigned H_BP      = 48,
  parameter int unsigned V_ACTIVE  = 480,
  parameter int unsigned V_FP      = 10,
  parameter int unsigned V_SYNC    = 2,
  parameter int unsigned V_BP      = 33,
  parameter int unsigned ADDR_W    = 19,
  parameter int unsigned NUM_MODES = 4,
  parameter int unsigned MODE_W    = 3,
  parameter int unsigned PIPE_LAT  = 2
) (
  input  logic                      iVGA_CLK,
  input  logic                      iRST,
  input  logic [MODE_W-1:0]         iMODE,
  input  logic [NUM_MODES*24-1:0]   iRGB,
  output logic [ADDR_W-1:0]         oADDR,
  output logic [9:0]                oX,
  output logic [9:0]                oY,
  output logic                      oACTIVE,
  output logic                      oFRAME_START,
  output logic [15:0]               oFRAME_CNT,
  output logic [MODE_W-1:0]         oMODE,
  output logic                      oHS,
  output logic                      oVS,
  output logic                      oBLANK_n,
  output logic [7:0]                oB,
  output logic [7:0]                oG,
  output logic [7:0]                oR
);

  localparam int unsigned H_TOTAL      = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL      = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned H_W          = $clog2(H_TOTAL);
  localparam int unsigned V_W          = $clog2(V_TOTAL);
  localparam int unsigned H_SYNC_START = H_ACTIVE + H_FP;
  localparam int unsigned H_SYNC_END   = H_SYNC_START + H_SYNC;
  localparam int unsigned V_SYNC_START = V_ACTIVE + V_FP;
  localparam int unsigned V_SYNC_END   = V_SYNC_START + V_SYNC;
  localparam int unsigned DLY          = PIPE_LAT + 2;

  logic [H_W-1:0]    h;
  logic [V_W-1:0]    v;
  logic              h_last_c;
  logic              v_last_c;
  logic              visible_c;
  logic              origin_c;
  logic              hs_c;
  logic              vs_c;
  logic [ADDR_W-1:0] addr_nxt;
  logic [MODE_W-1:0] mode_q;
  logic [15:0]       frame_cnt;
  logic [DLY-1:0]    hs_d;
  logic [DLY-1:0]    vs_d;
  logic [DLY-1:0]    blank_d;
  logic [MODE_W-1:0] mode_d [PIPE_LAT];
  logic [MODE_W-1:0] mode_sel_c;
  logic [23:0]       colour_c;
  logic [23:0]       rgb_q;

  // Raw timing decode from the current counter values
  always_comb begin
    h_last_c  = (h == H_W'(H_TOTAL - 1));
    v_last_c  = (v == V_W'(V_TOTAL - 1));
    visible_c = (h < H_W'(H_ACTIVE)) && (v < V_W'(V_ACTIVE));
    origin_c  = (h == '0) && (v == '0);
    hs_c      = !((h >= H_W'(H_SYNC_START)) && (h < H_W'(H_SYNC_END)));
    vs_c      = !((v >= V_W'(V_SYNC_START)) && (v < V_W'(V_SYNC_END)));
  end

  // Horizontal and vertical counters
  always_ff @(posedge iVGA_CLK) begin
    if (iRST) begin
      h <= '0;
      v <= '0;
    end else if (h_last_c) begin
      h <= '0;
      v <= v_last_c ? '0 : v + V_W'(1);
    end else begin
      h <= h + H_W'(1);
    end
  end

  // Coordinates and incremental address; addr_nxt is the next visible address
  always_ff @(posedge iVGA_CLK) begin
    if (iRST) begin
      oX           <= '0;
      oY           <= '0;
      oACTIVE      <= 1'b0;
      oFRAME_START <= 1'b0;
      oADDR        <= '0;
      addr_nxt     <= '0;
    end else begin
      oX           <= 10'(h);
      oY           <= 10'(v);
      oACTIVE      <= visible_c;
      oFRAME_START <= origin_c;
      if (origin_c) begin
        oADDR    <= '0;
        addr_nxt <= ADDR_W'(1);
      end else if (visible_c) begin
        oADDR    <= addr_nxt;
        addr_nxt <= addr_nxt + ADDR_W'(1);
      end
    end
  end

  // Frame-start mode latch and frame counter
  always_ff @(posedge iVGA_CLK) begin
    if (iRST) begin
      mode_q    <= '0;
      frame_cnt <= '0;
    end else if (origin_c) begin
      mode_q    <= iMODE;
      frame_cnt <= frame_cnt + 16'd1;
    end
  end

  assign oMODE      = mode_q;
  assign oFRAME_CNT = frame_cnt;

  // Sync/blank shift registers; reset loads the blank state into every stage
  always_ff @(posedge iVGA_CLK) begin
    if (iRST) begin
      hs_d    <= '1;
      vs_d    <= '1;
      blank_d <= '0;
    end else begin
      hs_d    <= {hs_d[DLY-2:0], hs_c};
      vs_d    <= {vs_d[DLY-2:0], vs_c};
      blank_d <= {blank_d[DLY-2:0], visible_c};
    end
  end

  // Mode delay so the mux switches exactly on the first pixel of a frame
  always_ff @(posedge iVGA_CLK) begin
    if (iRST) begin
      for (int i = 0; i < PIPE_LAT; i++) mode_d[i] <= '0;
    end else begin
      mode_d[0] <= mode_q;
      for (int i = 1; i < PIPE_LAT; i++) mode_d[i] <= mode_d[i-1];
    end
  end

  assign mode_sel_c = mode_d[PIPE_LAT-1];

`ifdef VGA_TEST_PATTERN_EN
  localparam int unsigned BAR_W    = H_ACTIVE / 8;
  localparam int unsigned BAR_PX_W = (BAR_W > 1) ? $clog2(BAR_W) : 1;

  logic [BAR_PX_W-1:0] bar_px;
  logic [2:0]          bar_idx;
  logic [2:0]          bar_d [PIPE_LAT+1];

  // Bar index tracked alongside h, avoiding a divider
  always_ff @(posedge iVGA_CLK) begin
    if (iRST) begin
      bar_px  <= '0;
      bar_idx <= '0;
    end else if (h_last_c) begin
      bar_px  <= '0;
      bar_idx <= '0;
    end else if (bar_px == BAR_PX_W'(BAR_W - 1)) begin
      bar_px  <= '0;
      bar_idx <= bar_idx + 3'd1;
    end else begin
      bar_px  <= bar_px + BAR_PX_W'(1);
    end
  end

  // Bar index delayed to the colour-mux cycle
  always_ff @(posedge iVGA_CLK) begin
    if (iRST) begin
      for (int i = 0; i <= PIPE_LAT; i++) bar_d[i] <= '0;
    end else begin
      bar_d[0] <= bar_idx;
      for (int i = 1; i <= PIPE_LAT; i++) bar_d[i] <= bar_d[i-1];
    end
  end
`endif

  // Channel select; unknown modes give black
  always_comb begin
    colour_c = '0;
    for (int k = 0; k < NUM_MODES; k++) begin
      if (mode_sel_c == MODE_W'(k)) colour_c = iRGB[24*k +: 24];
    end
`ifdef VGA_TEST_PATTERN_EN
    if (mode_sel_c == MODE_W'(NUM_MODES)) begin
      colour_c = {{8{bar_d[PIPE_LAT][2]}}, {8{bar_d[PIPE_LAT][1]}},
                  {8{bar_d[PIPE_LAT][0]}}};
    end
`endif
  end

  // Output colour register, forced black outside the visible area
  always_ff @(posedge iVGA_CLK) begin
    if (iRST) rgb_q <= '0;
    else      rgb_q <= blank_d[PIPE_LAT] ? colour_c : 24'h000000;
  end

  assign oHS      = hs_d[DLY-1];
  assign oVS      = vs_d[DLY-1];
  assign oBLANK_n = blank_d[DLY-1];
  assign oB       = rgb_q[23:16];
  assign oG       = rgb_q[15:8];
  assign oR       = rgb_q[7:0];

endmodule
